// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Optional feature macro: ILLEGAL_TRAP_EN adds the TRAP state.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
`ifdef ILLEGAL_TRAP_EN
        , TRAP    = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_ctrl;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-controls decoder; only FETCH looks at mem_ready,
// so the PC and IR are written once, on the cycle memory delivers the word.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: default everything first so no path through the case infers a latch.
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_ctrl   = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.pc_write_cond = 1'b1;
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_ctrl   = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath with memory-ready stalls.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcodes lock into TRAP).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_ctrl,
    output logic           pc_write_cond,
    output logic           instr_type,
    output logic [1:0]     pc_source,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [3:0]     state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic           illegal_op
`endif
);

    state_t state, state_next;
    ctrl_t  dec, ctrl;
    logic   instr_type_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            instr_type_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE) instr_type_q <= opcode[0];
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:     state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW))        state_next = MEM_ADDR;
                else if (opcode == OPW'(OP_RTYPE))                         state_next = R_EXEC;
                else if (opcode == OPW'(OP_BEQ) || opcode == OPW'(OP_BNE)) state_next = BRANCH;
                else if (opcode == OPW'(OP_J))                             state_next = JUMP;
                else if (opcode == OPW'(OP_ADDI))                          state_next = ADDI_EXEC;
`ifdef ILLEGAL_TRAP_EN
                else                                                       state_next = TRAP;
`else
                else                                                       state_next = FETCH;
`endif
            end
            MEM_ADDR: begin
                if (opcode == OPW'(OP_LW))      state_next = MEM_READ;
                else if (opcode == OPW'(OP_SW)) state_next = MEM_WRITE;
                else                            state_next = FETCH;
            end
            MEM_READ:  state_next = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_next = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    state_next = R_WB;
            ADDI_EXEC: state_next = ADDI_WB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:      state_next = TRAP;
`endif
            default:   state_next = FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                     illegal_op <= 1'b0;
        else if (state == DECODE && state_next == TRAP) illegal_op <= 1'b1;
    end
`endif

    mips_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (dec)
    );

    // Reset must also silence the FETCH decodes, which would otherwise be live.
    always_comb begin
        ctrl = reset ? '0 : dec;
    end

    assign pc_ctrl       = ctrl.pc_ctrl;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign instr_type    = instr_type_q;
    assign state_o       = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected cycle lists built from the
// instruction-class rules, with random memory stalls and random opcodes.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic       clk, reset, mem_ready;
    logic [5:0] opcode;
    logic       pc_ctrl, pc_write_cond, instr_type, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_o;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    mips_multicycle_ctrl #(.OPW(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_ctrl(pc_ctrl), .pc_write_cond(pc_write_cond), .instr_type(instr_type),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state_o(state_o)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] st;
        logic       pc, pwc;
        logic [1:0] psrc;
        logic       iord, mr, mw, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, aop;
    } ctl_t;

    typedef struct packed {
        ctl_t ctl;
        logic rdy;
        logic chk_it;
        logic it;
        logic ill;
    } cyc_t;

    int   checks = 0;
    int   failures = 0;
    cyc_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t sample();
        return {state_o, pc_ctrl, pc_write_cond, pc_source, iord, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};
    endfunction

    // A cycle where mem_ready should not matter gets a random value.
    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c = '0;
        c.ctl.st = st;
        c.rdy    = 1'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic mem_phase(input cyc_t c, input int stalls);
        for (int k = 0; k < stalls; k++) begin
            c.rdy = 1'b0;
            q.push_back(c);
        end
        c.rdy = 1'b1;
        q.push_back(c);
    endtask

    task automatic build(input logic [5:0] op, input int fs, input int ms);
        cyc_t c;
        q.delete();
        c = blank(4'd0); c.ctl.mr = 1'b1; c.ctl.asb = 2'b01;
        for (int k = 0; k < fs; k++) begin
            c.rdy = 1'b0;
            q.push_back(c);
        end
        c.rdy = 1'b1; c.ctl.irw = 1'b1; c.ctl.pc = 1'b1;
        q.push_back(c);
        c = blank(4'd1); c.ctl.asb = 2'b11; q.push_back(c);
        case (op)
            T_LW, T_SW: begin
                c = blank(4'd2); c.ctl.asa = 1'b1; c.ctl.asb = 2'b10; q.push_back(c);
                if (op == T_LW) begin
                    c = blank(4'd3); c.ctl.mr = 1'b1; c.ctl.iord = 1'b1; mem_phase(c, ms);
                    c = blank(4'd4); c.ctl.rw = 1'b1; c.ctl.m2r = 1'b1; q.push_back(c);
                end else begin
                    c = blank(4'd5); c.ctl.mw = 1'b1; c.ctl.iord = 1'b1; mem_phase(c, ms);
                end
            end
            T_R: begin
                c = blank(4'd6); c.ctl.asa = 1'b1; c.ctl.aop = 2'b10; q.push_back(c);
                c = blank(4'd7); c.ctl.rw = 1'b1; c.ctl.rdst = 1'b1; q.push_back(c);
            end
            T_BEQ, T_BNE: begin
                c = blank(4'd8); c.ctl.pwc = 1'b1; c.ctl.asa = 1'b1; c.ctl.aop = 2'b01;
                c.ctl.psrc = 2'b01; c.chk_it = 1'b1; c.it = (op == T_BNE);
                q.push_back(c);
            end
            T_J: begin
                c = blank(4'd9); c.ctl.pc = 1'b1; c.ctl.psrc = 2'b10; q.push_back(c);
            end
            T_ADDI: begin
                c = blank(4'd10); c.ctl.asa = 1'b1; c.ctl.asb = 2'b10; q.push_back(c);
                c = blank(4'd11); c.ctl.rw = 1'b1; q.push_back(c);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int k = 0; k < 10; k++) begin
                    c = blank(4'd12); c.ill = 1'b1; q.push_back(c);
                end
`endif
            end
        endcase
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic run_instr(input string name, input logic [5:0] op, input int fs, input int ms);
        build(op, fs, ms);
        opcode = op;
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            #1;
            check($sformatf("%s_cyc%0d", name, i), 32'(sample()), 32'(q[i].ctl));
            if (q[i].chk_it) check($sformatf("%s_instr_type", name), 32'(instr_type), 32'(q[i].it));
`ifdef ILLEGAL_TRAP_EN
            check($sformatf("%s_illegal_op%0d", name, i), 32'(illegal_op), 32'(q[i].ill));
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        ctl_t       exp_c;
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI, T_BAD};

        reset = 1'b1; mem_ready = 1'b1; opcode = T_LW;
        #12;
        check("reset_ctl", 32'(sample()), 32'h0);
        check("reset_instr_type", 32'(instr_type), 32'h0);
`ifdef ILLEGAL_TRAP_EN
        check("reset_illegal_op", 32'(illegal_op), 32'h0);
`endif
        #3 reset = 1'b0;

        run_instr("lw", T_LW, 0, 0);
        run_instr("rtype", T_R, 0, 0);
        run_instr("bne", T_BNE, 0, 0);
        run_instr("beq", T_BEQ, 0, 0);
        run_instr("sw_stall", T_SW, 3, 3);
        run_instr("j", T_J, 1, 0);
        run_instr("addi", T_ADDI, 0, 0);

        // Reset arriving while lw waits on memory.
        opcode = T_LW; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        exp_c = '0; exp_c.st = 4'd3; exp_c.mr = 1'b1; exp_c.iord = 1'b1;
        check("lw_mem_stall", 32'(sample()), 32'(exp_c));
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        check("reset_mid_ctl", 32'(sample()), 32'h0);
        check("reset_mid_instr_type", 32'(instr_type), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_instr("after_reset", T_R, 0, 0);

`ifndef ILLEGAL_TRAP_EN
        run_instr("bad_nop", T_BAD, 0, 0);
`endif

        for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
            logic [5:0] op = ops[$urandom_range(0, 6)];
`else
            logic [5:0] op = ops[$urandom_range(0, 7)];
`endif
            run_instr($sformatf("rnd%0d", n), op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

`ifdef ILLEGAL_TRAP_EN
        run_instr("trap", T_BAD, 0, 0);
        reset = 1'b1;
        #1;
        check("trap_reset_illegal_op", 32'(illegal_op), 32'h0);
        check("trap_reset_ctl", 32'(sample()), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the PC write controls (`pc_ctrl`, `pc_write_cond`, `instr_type`), memory, IR, register-file and ALU-mux selects. Memory accesses use a ready handshake, so the FSM stalls on slow memory without corrupting the PC.

## Interface
Parameters:
- `OPW`, default 6: opcode width (instruction bits [31:26]).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  OPW  instruction bits [31:26], taken from the IR.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_ctrl`  out  1  unconditional PC write.
- `pc_write_cond`  out  1  conditional (branch) PC write.
- `instr_type`  out  1  branch sense: 0 = beq, 1 = bne.
- `pc_source`  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  load the IR.
- `reg_dst`  out  1  destination select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field.
- `state_o`  out  4  current state, for debug.
- `illegal_op`  out  1  only when `ILLEGAL_TRAP_EN` is defined.

## Operation
Recognised opcodes: R-type `000000`, lw `100011`, sw `101011`, beq `000100`, bne `000101`, j `000010`, addi `001000`.

States, with their encodings, active outputs and next-state transitions:
- FETCH (0): `mem_read`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_ctrl` are asserted only when `mem_ready`=1.
  - Holds in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE (1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target is computed into ALUOut). Next state by opcode:
  - lw or sw → MEM_ADDR
  - R-type → R_EXEC
  - beq or bne → BRANCH
  - j → JUMP
  - addi → ADDI_EXEC
  - any other opcode → FETCH (treated as a NOP)
- MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (3): `mem_read`, `iord`=1. Holds until `mem_ready`=1, then goes to MEM_WB.
- MEM_WB (4): `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WRITE (5): `mem_write`, `iord`=1. Holds until `mem_ready`=1, then goes to FETCH.
- R_EXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to R_WB.
- R_WB (7): `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH (8): `pc_write_cond`, `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01; `instr_type`=0 for beq, 1 for bne. Goes to FETCH.
- JUMP (9): `pc_ctrl`, `pc_source`=10. Goes to FETCH.
- ADDI_EXEC (10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to ADDI_WB.
- ADDI_WB (11): `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.

Output rules:
- Every output not listed for a state is 0.
- `pc_ctrl` and `pc_write_cond` are never asserted together.
- `instr_type` is registered in DECODE from `opcode` bit 0 and held until the next DECODE.
- Unused state encodings (12–15) go to FETCH on the next edge.

## Timing
- Outputs are Moore decodes of the state register. The only exceptions are `ir_write` and `pc_ctrl` in FETCH, which are gated combinationally by `mem_ready`.
- Cycles per instruction with `mem_ready` tied to 1: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle to the instruction.
- During a stall every output is held constant. `pc_ctrl` stays 0 in a stalled FETCH, so the PC is written exactly once per fetch.
- While `reset`=1, asynchronously:
  - state is FETCH;
  - every output is forced to 0, including the FETCH decodes;
  - `instr_type` is 0 and `illegal_op` is 0.
- Deasserting `reset` mid-instruction restarts at FETCH; partial state is never resumed.
- `opcode` is sampled only in DECODE and MEM_ADDR.

## Configuration
`ILLEGAL_TRAP_EN`:
- Defined:
  - An unrecognised opcode in DECODE goes to TRAP (state 12).
  - TRAP holds forever with every output 0 except `illegal_op`=1, which is sticky until `reset`.
  - The `illegal_op` port exists.
- Undefined:
  - An unrecognised opcode goes to FETCH; the PC has already advanced by 4.
  - There is no `illegal_op` port and no TRAP state.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the `state_t` enum with the encodings above;
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_ADDI`);
  - `alu_op`, `alu_src_b` and `pc_source` constants.
- Sub-module `mips_ctrl_outdec`: a purely combinational state-to-controls decoder, taking `state` and `mem_ready` as inputs.
- The top level keeps the state register, the `instr_type` register, the next-state logic and the optional trap flag.

## Test plan
- Reset held for 15 ns, then lw with `mem_ready`=1 → states 0,1,2,3,4,0.
  - `pc_ctrl`=1 only in cycle 1.
  - `reg_write`=1 and `mem_to_reg`=1 in cycle 5.
- R-type → states 0,1,6,7,0.
  - `alu_op`=10 in R_EXEC.
  - `reg_write`=1 and `reg_dst`=1 in R_WB.
- bne → BRANCH with `pc_write_cond`=1, `instr_type`=1, `pc_source`=01 and `pc_ctrl`=0.
  - A following beq → `instr_type`=0.
- `mem_ready` low for 3 cycles in FETCH, then in MEM_WRITE for sw:
  - FETCH lasts 4 cycles with `pc_ctrl` pulsing exactly once;
  - `mem_write` is held for 4 cycles.
- `reset` asserted in the MEM_READ stall → asynchronously state 0 and all outputs 0; after release, FETCH restarts.
- Opcode `111111`:
  - with `ILLEGAL_TRAP_EN` → state 12 and `illegal_op`=1, held for 10 cycles;
  - without it → DECODE then FETCH.
